// File: rtl/circ_pkg.sv
// Shared types and constants for the circularity scheduler.
package circ_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned CIRC_MAX = 100;
  localparam int unsigned CIRC_W   = 7;

  // Operand width large enough to hold the full-frame pixel count
  function automatic int unsigned circ_aw(input int unsigned width, input int unsigned height);
    return $clog2(width * height) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDW-1:0]     id_c,
  output logic               any_c
);

  always_comb begin
    logic [IDW-1:0] idx;
    gnt_c = '0;
    id_c  = '0;
    any_c = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NUM_REQ);
      if (!any_c && req[idx]) begin
        any_c      = 1'b1;
        gnt_c[idx] = 1'b1;
        id_c       = idx;
      end
    end
  end

endmodule

// File: rtl/circularity_scheduler.sv
// Shares one external circularity unit between NUM_REQ blob trackers and
// tracks the roundest good blob of the current frame.
module circularity_scheduler
  import circ_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 180,
  parameter  int unsigned HEIGHT  = 320,
  parameter  int unsigned TIMEOUT = 63,
  localparam int unsigned AW      = circ_aw(WIDTH, HEIGHT),
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [NUM_REQ-1:0]    req_valid_in,
  input  logic [NUM_REQ*AW-1:0] req_area_in,
  input  logic [NUM_REQ*AW-1:0] req_perim_in,
  output logic [NUM_REQ-1:0]    req_ready_out,
  output logic [AW-1:0]         circ_area_out,
  output logic [AW-1:0]         circ_perim_out,
  output logic                  circ_valid_out,
  input  logic                  circ_busy_in,
  input  logic                  circ_valid_in,
  input  logic [AW-1:0]         circ_result_in,
  output logic                  res_valid_out,
  output logic [IDW-1:0]        res_id_out,
  output logic [CIRC_W-1:0]     res_circ_out,
  output logic                  res_err_out,
  input  logic                  frame_start_in,
  output logic                  best_valid_out,
  output logic [IDW-1:0]        best_id_out,
  output logic [CIRC_W-1:0]     best_circ_out
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // Last WAIT cycle that can still accept a result; the error then lands TIMEOUT cycles after the start pulse
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [CIRC_W-1:0]   circ_q, circ_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  ready_d;
  logic [AW-1:0]       area_d, perim_d;
  logic                circ_valid_d, res_valid_d, res_err_d;
  logic [IDW-1:0]      res_id_d, best_id_d;
  logic [CIRC_W-1:0]   res_circ_d, best_circ_d;
  logic                best_valid_d;

  logic [NUM_REQ-1:0]  gnt_c;
  logic [IDW-1:0]      gid_c;
  logic                any_c;
  logic [AW-1:0]       area_a  [NUM_REQ];
  logic [AW-1:0]       perim_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign area_a[g]  = req_area_in[g*AW +: AW];
    assign perim_a[g] = req_perim_in[g*AW +: AW];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid_in),
    .ptr   (rr_ptr_q),
    .gnt_c (gnt_c),
    .id_c  (gid_c),
    .any_c (any_c)
  );

  // Next-state, datapath and registered-output decisions
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    timer_d      = timer_q;
    id_d         = id_q;
    circ_d       = circ_q;
    err_d        = err_q;
    ready_d      = '0;
    area_d       = circ_area_out;
    perim_d      = circ_perim_out;
    circ_valid_d = 1'b0;
    res_valid_d  = 1'b0;
    res_id_d     = res_id_out;
    res_circ_d   = res_circ_out;
    res_err_d    = res_err_out;
    best_valid_d = best_valid_out;
    best_id_d    = best_id_out;
    best_circ_d  = best_circ_out;

    if (frame_start_in) begin
      best_valid_d = 1'b0;
      best_id_d    = '0;
      best_circ_d  = '0;
    end

    case (state_q)
      IDLE: begin
        if (any_c) begin
          ready_d  = gnt_c;
          id_d     = gid_c;
          area_d   = area_a[gid_c];
          perim_d  = perim_a[gid_c];
          rr_ptr_d = (gid_c == IDW'(NUM_REQ - 1)) ? '0 : gid_c + IDW'(1);
          if (area_a[gid_c] == '0 || perim_a[gid_c] == '0) begin
            err_d   = 1'b1;
            circ_d  = '0;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!circ_busy_in) begin
          circ_valid_d = 1'b1;
          timer_d      = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (circ_valid_in) begin
          circ_d  = (circ_result_in > AW'(CIRC_MAX)) ? CIRC_W'(CIRC_MAX) : CIRC_W'(circ_result_in);
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timer_q == TMO_LAST) begin
          circ_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        res_circ_d  = circ_q;
        res_err_d   = err_q;
        // Strictly greater keeps the earlier result on a tie
        if (!err_q && (!best_valid_d || circ_q > best_circ_d)) begin
          best_valid_d = 1'b1;
          best_id_d    = id_q;
          best_circ_d  = circ_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      timer_q        <= '0;
      id_q           <= '0;
      circ_q         <= '0;
      err_q          <= 1'b0;
      req_ready_out  <= '0;
      circ_area_out  <= '0;
      circ_perim_out <= '0;
      circ_valid_out <= 1'b0;
      res_valid_out  <= 1'b0;
      res_id_out     <= '0;
      res_circ_out   <= '0;
      res_err_out    <= 1'b0;
      best_valid_out <= 1'b0;
      best_id_out    <= '0;
      best_circ_out  <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      timer_q        <= timer_d;
      id_q           <= id_d;
      circ_q         <= circ_d;
      err_q          <= err_d;
      req_ready_out  <= ready_d;
      circ_area_out  <= area_d;
      circ_perim_out <= perim_d;
      circ_valid_out <= circ_valid_d;
      res_valid_out  <= res_valid_d;
      res_id_out     <= res_id_d;
      res_circ_out   <= res_circ_d;
      res_err_out    <= res_err_d;
      best_valid_out <= best_valid_d;
      best_id_out    <= best_id_d;
      best_circ_out  <= best_circ_d;
    end
  end

endmodule

// File: tb/tb_circularity_scheduler.sv
// Directed + randomized bench for circularity_scheduler with a transaction-level reference model.
module tb_circularity_scheduler;
  import circ_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 180;
  localparam int unsigned HEIGHT  = 320;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned AW      = circ_aw(WIDTH, HEIGHT);
  localparam int unsigned IDW     = $clog2(NUM_REQ);

  logic                  clk_in = 1'b0;
  logic                  rst_n_in;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_area, req_perim;
  logic [NUM_REQ-1:0]    req_ready_out;
  logic [AW-1:0]         circ_area_out, circ_perim_out;
  logic                  circ_valid_out;
  logic                  circ_busy;
  logic                  circ_valid_i;
  logic [AW-1:0]         circ_result;
  logic                  res_valid_out;
  logic [IDW-1:0]        res_id_out;
  logic [CIRC_W-1:0]     res_circ_out;
  logic                  res_err_out;
  logic                  frame_start;
  logic                  best_valid_out;
  logic [IDW-1:0]        best_id_out;
  logic [CIRC_W-1:0]     best_circ_out;

  logic [AW-1:0] area_v  [NUM_REQ];
  logic [AW-1:0] perim_v [NUM_REQ];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_ptr;
  bit m_bv;
  int m_bid;
  int m_bc;

  always #5 clk_in = ~clk_in;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_area[g*AW +: AW]  = area_v[g];
    assign req_perim[g*AW +: AW] = perim_v[g];
  end

  circularity_scheduler #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid),
    .req_area_in    (req_area),
    .req_perim_in   (req_perim),
    .req_ready_out  (req_ready_out),
    .circ_area_out  (circ_area_out),
    .circ_perim_out (circ_perim_out),
    .circ_valid_out (circ_valid_out),
    .circ_busy_in   (circ_busy),
    .circ_valid_in  (circ_valid_i),
    .circ_result_in (circ_result),
    .res_valid_out  (res_valid_out),
    .res_id_out     (res_id_out),
    .res_circ_out   (res_circ_out),
    .res_err_out    (res_err_out),
    .frame_start_in (frame_start),
    .best_valid_out (best_valid_out),
    .best_id_out    (best_id_out),
    .best_circ_out  (best_circ_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req_ready_out, circ_area_out, circ_perim_out, circ_valid_out, res_valid_out,
                res_id_out, res_circ_out, res_err_out, best_valid_out, best_id_out, best_circ_out});
  endfunction

  // Round-robin rule: first pending requester at or after the pointer
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      int idx;
      idx = (ptr + k) % int'(NUM_REQ);
      if (v[IDW'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clear_best();
    m_bv  = 1'b0;
    m_bid = 0;
    m_bc  = 0;
  endtask

  task automatic check_best(input string tag);
    check({tag, "_best_valid"}, 64'(best_valid_out), 64'(m_bv));
    check({tag, "_best_id"},    64'(best_id_out),    64'(m_bid));
    check({tag, "_best_circ"},  64'(best_circ_out),  64'(m_bc));
  endtask

  task automatic do_reset();
    rst_n_in     = 1'b0;
    req_valid    = '0;
    circ_busy    = 1'b0;
    circ_valid_i = 1'b0;
    circ_result  = '0;
    frame_start  = 1'b0;
    step();
    step();
    check("reset_outputs", all_outs(), 64'(0));
    rst_n_in = 1'b1;
    m_ptr = 0;
    model_clear_best();
  endtask

  // One transaction from the currently pending requests; FSM must be idle on entry.
  task automatic txn(input int lat, input int result, input bit hang, input int busy, input bit fs);
    int             id;
    logic [IDW-1:0] gid;
    logic [AW-1:0]  a, p;
    bit             degen, exp_err, seen;
    int             exp_circ, exp_k, k;
    id = pick(req_valid, m_ptr);
    if (id < 0) $fatal(1, "FAIL txn_setup no pending request");
    gid   = IDW'(id);
    a     = area_v[gid];
    p     = perim_v[gid];
    degen = (a == '0) || (p == '0);
    circ_busy = (busy > 0);
    step();
    check("ready_onehot", 64'(req_ready_out), 64'(1) << id);
    check("operand_area", 64'(circ_area_out), 64'(a));
    check("operand_perim", 64'(circ_perim_out), 64'(p));
    check("no_start_at_grant", 64'(circ_valid_out), 64'(0));
    req_valid[gid] = 1'b0;
    m_ptr = (id + 1) % int'(NUM_REQ);
    if (degen) begin
      exp_err  = 1'b1;
      exp_circ = 0;
      frame_start = fs;
      step();
      frame_start = 1'b0;
      check("degen_no_start", 64'(circ_valid_out), 64'(0));
    end else begin
      for (int b = 0; b < busy; b++) begin
        step();
        check("held_while_busy", 64'(circ_valid_out), 64'(0));
      end
      circ_busy = 1'b0;
      step();
      check("start_pulse", 64'(circ_valid_out), 64'(1));
      if (hang || lat >= int'(TIMEOUT)) begin
        exp_err  = 1'b1;
        exp_circ = 0;
        exp_k    = int'(TIMEOUT);
      end else begin
        exp_err  = 1'b0;
        exp_circ = (result > int'(CIRC_MAX)) ? int'(CIRC_MAX) : result;
        exp_k    = lat + 1;
      end
      k    = 0;
      seen = 1'b0;
      while (!seen && k < int'(TIMEOUT) + 8) begin
        circ_valid_i = !hang && (k + 1 == lat);
        circ_result  = AW'(result);
        frame_start  = fs && (k + 1 == exp_k);
        step();
        k++;
        circ_valid_i = 1'b0;
        frame_start  = 1'b0;
        if (k == 1) check("start_single_cycle", 64'(circ_valid_out), 64'(0));
        if (res_valid_out) seen = 1'b1;
      end
      check("res_latency", 64'(k), 64'(exp_k));
    end
    check("res_valid", 64'(res_valid_out), 64'(1));
    check("res_id", 64'(res_id_out), 64'(id));
    check("res_circ", 64'(res_circ_out), 64'(exp_circ));
    check("res_err", 64'(res_err_out), 64'(exp_err));
    if (fs) model_clear_best();
    if (!exp_err && (!m_bv || exp_circ > m_bc)) begin
      m_bv  = 1'b1;
      m_bid = id;
      m_bc  = exp_circ;
    end
    check_best("txn");
  endtask

  task automatic set_req(input int id, input int a, input int p);
    area_v[IDW'(id)]    = AW'(a);
    perim_v[IDW'(id)]   = AW'(p);
    req_valid[IDW'(id)] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      area_v[IDW'(i)]  = '0;
      perim_v[IDW'(i)] = '0;
    end
    do_reset();

    // Single request, the canonical example
    set_req(2, 1000, 120);
    txn(5, 87, 1'b0, 0, 1'b0);

    // Fairness from pointer 0: order 0, 1, 3, then 0 again
    do_reset();
    set_req(0, 400, 70);
    set_req(1, 900, 110);
    set_req(3, 2500, 200);
    txn(3, 40, 1'b0, 0, 1'b0);
    txn(2, 60, 1'b0, 1, 1'b0);
    txn(4, 55, 1'b0, 0, 1'b0);
    set_req(0, 640, 90);
    txn(1, 30, 1'b0, 0, 1'b0);

    // Degenerate perimeter on requester 1
    set_req(1, 800, 0);
    txn(3, 99, 1'b0, 0, 1'b0);

    // Clamp to 100, then a tie from another requester does not replace it
    set_req(2, 3000, 190);
    txn(2, 130, 1'b0, 2, 1'b0);
    set_req(3, 3100, 195);
    txn(2, 100, 1'b0, 0, 1'b0);

    // Timeout with a second requester waiting; boundary latencies
    set_req(0, 500, 80);
    set_req(1, 700, 95);
    txn(0, 0, 1'b1, 0, 1'b0);
    txn(int'(TIMEOUT) - 1, 50, 1'b0, 0, 1'b0);
    set_req(2, 450, 75);
    txn(int'(TIMEOUT), 77, 1'b0, 0, 1'b0);

    // Stand-alone frame start, then frame start coinciding with DONE
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    model_clear_best();
    check_best("frame_clear");
    set_req(3, 1200, 130);
    txn(3, 90, 1'b0, 0, 1'b0);
    set_req(0, 1500, 300);
    txn(3, 20, 1'b0, 0, 1'b1);

    // Reset while waiting on the unit, then a stale result
    set_req(2, 500, 80);
    step();
    req_valid = '0;
    step();
    step();
    step();
    rst_n_in = 1'b0;
    #1;
    check("reset_async", all_outs(), 64'(0));
    step();
    rst_n_in     = 1'b1;
    m_ptr        = 0;
    model_clear_best();
    circ_valid_i = 1'b1;
    circ_result  = AW'(42);
    step();
    circ_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_res_after_reset", 64'(res_valid_out), 64'(0));
    end
    check("outputs_after_stale", all_outs(), 64'(0));

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int  lat;
      bit  hang;
      if (req_valid == '0 && $urandom_range(0, 5) == 0) begin
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        model_clear_best();
        check_best("rand_frame_clear");
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!req_valid[IDW'(i)] && $urandom_range(0, 1) == 1) begin
          area_v[IDW'(i)]  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, WIDTH * HEIGHT));
          perim_v[IDW'(i)] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 2000));
          req_valid[IDW'(i)] = 1'b1;
        end
      end
      if (req_valid == '0) set_req(0, 100, 40);
      hang = ($urandom_range(0, 11) == 0);
      lat  = ($urandom_range(0, 7) == 0) ? int'(TIMEOUT) - 1 : int'($urandom_range(1, 8));
      txn(lat, int'($urandom_range(0, 150)), hang, int'($urandom_range(0, 3)),
          $urandom_range(0, 4) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
